// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream transmit endpoint: occupancy states and the
// default-width beat layout.
package axis_pkg;

   localparam int AXIS_DATA_WIDTH  = 32;
   localparam int AXIS_TID_WIDTH   = 2;
   localparam int AXIS_TUSER_WIDTH = 2;

   typedef enum logic [1:0] {
      AXIS_MST_EMPTY = 2'd0,
      AXIS_MST_ONE   = 2'd1,
      AXIS_MST_FULL  = 2'd2
   } axis_mst_state_e;

   typedef struct packed {
      logic [AXIS_DATA_WIDTH-1:0]   tdata;
      logic [AXIS_DATA_WIDTH/8-1:0] tstrb;
      logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
      logic                         tlast;
      logic [AXIS_TID_WIDTH-1:0]    tid;
      logic [AXIS_TUSER_WIDTH-1:0]  tuser;
   } axis_beat_t;

endpackage

// File: rtl/axis_pkt_counter.sv
// Packet bookkeeping on the AXIS side: completed-packet count (wrapping) and
// a flag that is set while a packet is partially sent.
module axis_pkt_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 axi_aclk,
   input  logic                 axi_areset,
   input  logic                 fire,
   input  logic                 last,
   output logic [CNT_WIDTH-1:0] pkt_cnt,
   output logic                 in_packet
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         pkt_cnt   <= '0;
         in_packet <= 1'b0;
      end else if (fire) begin
         if (last) begin
            pkt_cnt   <= pkt_cnt + CNT_WIDTH'(1);
            in_packet <= 1'b0;
         end else begin
            in_packet <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_master.sv
// Transmit-side AXI-Stream endpoint: 2-entry skid buffer between a backend
// valid/ready producer and a registered AXIS master port, plus packet counters.
module axis_master
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int TID_WIDTH   = 2,
   parameter int TUSER_WIDTH = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                    axi_aclk,
   input  logic                    axi_areset,
   input  logic [DATA_WIDTH-1:0]   bk_data,
   input  logic [DATA_WIDTH/8-1:0] bk_tstrb,
   input  logic [DATA_WIDTH/8-1:0] bk_tkeep,
   input  logic [TID_WIDTH-1:0]    bk_tid,
   input  logic [TUSER_WIDTH-1:0]  bk_user,
   input  logic                    bk_tlast,
   input  logic                    bk_valid,
   output logic                    bk_ready,
   output logic                    axis_tvalid,
   output logic [DATA_WIDTH-1:0]   axis_tdata,
   output logic [DATA_WIDTH/8-1:0] axis_tstrb,
   output logic [DATA_WIDTH/8-1:0] axis_tkeep,
   output logic                    axis_tlast,
   output logic [TID_WIDTH-1:0]    axis_tid,
   output logic [TUSER_WIDTH-1:0]  axis_tuser,
   input  logic                    axis_tready,
   output logic [CNT_WIDTH-1:0]    pkt_cnt,
   output logic                    in_packet
);

   // Same field order as axis_beat_t, sized by this instance's parameters.
   typedef struct packed {
      logic [DATA_WIDTH-1:0]   tdata;
      logic [DATA_WIDTH/8-1:0] tstrb;
      logic [DATA_WIDTH/8-1:0] tkeep;
      logic                    tlast;
      logic [TID_WIDTH-1:0]    tid;
      logic [TUSER_WIDTH-1:0]  tuser;
   } beat_t;

   axis_mst_state_e state_q, state_d;
   beat_t           m_q, s_q, bk_beat;
   logic            ready_en_q;
   logic            in_fire, out_fire;
   logic            load_m_bk, load_m_s, load_s;

   assign bk_beat = '{tdata: bk_data, tstrb: bk_tstrb, tkeep: bk_tkeep,
                      tlast: bk_tlast, tid: bk_tid, tuser: bk_user};

   // bk_ready comes from flops only; ready_en_q holds it low through reset
   // and the edge that follows.
   assign bk_ready    = ready_en_q && (state_q != AXIS_MST_FULL);
   assign axis_tvalid = (state_q != AXIS_MST_EMPTY);
   assign in_fire     = bk_valid & bk_ready;
   assign out_fire    = axis_tvalid & axis_tready;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      load_m_bk = 1'b0;
      load_m_s  = 1'b0;
      load_s    = 1'b0;
      unique case (state_q)
         AXIS_MST_EMPTY: begin
            if (in_fire) begin
               load_m_bk = 1'b1;
               state_d   = AXIS_MST_ONE;
            end
         end
         AXIS_MST_ONE: begin
            if (in_fire && out_fire) begin
               load_m_bk = 1'b1;
            end else if (out_fire) begin
               state_d = AXIS_MST_EMPTY;
            end else if (in_fire) begin
               load_s  = 1'b1;
               state_d = AXIS_MST_FULL;
            end
         end
         AXIS_MST_FULL: begin
            if (out_fire) begin
               load_m_s = 1'b1;
               state_d  = AXIS_MST_ONE;
            end
         end
         default: state_d = AXIS_MST_EMPTY;
      endcase
   end

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state_q    <= AXIS_MST_EMPTY;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
      end
   end

   // NOTE: payload registers are reset too, so the AXIS bus never carries
   // stale data from before a reset, even while tvalid is low.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         m_q <= '0;
         s_q <= '0;
      end else begin
         if (load_m_bk)     m_q <= bk_beat;
         else if (load_m_s) m_q <= s_q;
         if (load_s)        s_q <= bk_beat;
      end
   end

   assign axis_tdata = m_q.tdata;
   assign axis_tstrb = m_q.tstrb;
   assign axis_tkeep = m_q.tkeep;
   assign axis_tlast = m_q.tlast;
   assign axis_tid   = m_q.tid;
   assign axis_tuser = m_q.tuser;

   axis_pkt_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_pkt_counter (
      .axi_aclk   (axi_aclk),
      .axi_areset (axi_areset),
      .fire       (out_fire),
      .last       (axis_tlast),
      .pkt_cnt    (pkt_cnt),
      .in_packet  (in_packet)
   );

endmodule

// File: tb/tb_axis_master.sv
// Self-checking bench for axis_master: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_axis_master;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic [3:0]  keep;
      logic        last;
      logic [1:0]  id;
      logic [1:0]  user;
   } tb_beat_t;

   logic             axi_aclk = 1'b0;
   logic             axi_areset;
   logic [31:0]      bk_data;
   logic [3:0]       bk_tstrb, bk_tkeep;
   logic [1:0]       bk_tid, bk_user;
   logic             bk_tlast, bk_valid, bk_ready;
   logic             axis_tvalid, axis_tlast, axis_tready;
   logic [31:0]      axis_tdata;
   logic [3:0]       axis_tstrb, axis_tkeep;
   logic [1:0]       axis_tid, axis_tuser;
   logic [CNT_W-1:0] pkt_cnt;
   logic             in_packet;
   tb_beat_t         out_beat;

   axis_master #(
      .DATA_WIDTH (32), .TID_WIDTH (2), .TUSER_WIDTH (2), .CNT_WIDTH (CNT_W)
   ) dut (
      .axi_aclk    (axi_aclk),
      .axi_areset  (axi_areset),
      .bk_data     (bk_data),
      .bk_tstrb    (bk_tstrb),
      .bk_tkeep    (bk_tkeep),
      .bk_tid      (bk_tid),
      .bk_user     (bk_user),
      .bk_tlast    (bk_tlast),
      .bk_valid    (bk_valid),
      .bk_ready    (bk_ready),
      .axis_tvalid (axis_tvalid),
      .axis_tdata  (axis_tdata),
      .axis_tstrb  (axis_tstrb),
      .axis_tkeep  (axis_tkeep),
      .axis_tlast  (axis_tlast),
      .axis_tid    (axis_tid),
      .axis_tuser  (axis_tuser),
      .axis_tready (axis_tready),
      .pkt_cnt     (pkt_cnt),
      .in_packet   (in_packet)
   );

   always #5 axi_aclk = ~axi_aclk;

   assign out_beat = {axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tid, axis_tuser};

   // Reference model: beats accepted but not yet sent, in order.
   tb_beat_t         exp_q[$];
   tb_beat_t         cur;
   logic [CNT_W-1:0] exp_cnt;
   logic             exp_inpkt;
   bit               ready_ok;
   int               tready_mode;   // 0 fixed, 1 toggle, 2 random
   int               vectors, miscompares;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input tb_beat_t b);
      cur      = b;
      bk_data  = b.data;
      bk_tstrb = b.strb;
      bk_tkeep = b.keep;
      bk_tlast = b.last;
      bk_tid   = b.id;
      bk_user  = b.user;
      bk_valid = 1'b1;
   endtask

   function automatic tb_beat_t mk(input logic [31:0] d, input logic l);
      tb_beat_t b;
      b = '{data: d, strb: 4'hF, keep: 4'hF, last: l, id: 2'd0, user: 2'd0};
      return b;
   endfunction

   // One clock cycle: check the DUT against the model mid-cycle, record the
   // handshakes, advance to the next falling edge.
   task automatic cycle(output bit fired);
      bit inf, outf;
      #1;
      inf  = bk_valid && bk_ready;
      outf = axis_tvalid && axis_tready;
      chk("bk_ready",  bk_ready,    ready_ok && (exp_q.size() < 2));
      chk("tvalid",    axis_tvalid, exp_q.size() != 0);
      chk("pkt_cnt",   pkt_cnt,     exp_cnt);
      chk("in_packet", in_packet,   exp_inpkt);
      if (axis_tvalid && exp_q.size() != 0) chk("beat", out_beat, exp_q[0]);
      if (outf && exp_q.size() != 0) begin
         if (exp_q[0].last) begin
            exp_cnt   = exp_cnt + 1'b1;
            exp_inpkt = 1'b0;
         end else begin
            exp_inpkt = 1'b1;
         end
         void'(exp_q.pop_front());
      end
      if (inf) exp_q.push_back(cur);
      fired = inf;
      @(posedge axi_aclk);
      ready_ok = 1'b1;
      @(negedge axi_aclk);
      if (tready_mode == 1)      axis_tready = ~axis_tready;
      else if (tready_mode == 2) axis_tready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_fire();
      bit f = 1'b0;
      for (int i = 0; i < 64 && !f; i++) cycle(f);
      if (!f) begin
         vectors++;
         miscompares++;
         $display("FAIL accept: beat 0x%0h not accepted within 64 cycles", cur.data);
      end
      bk_valid = 1'b0;
   endtask

   task automatic send(input tb_beat_t b);
      drive(b);
      wait_fire();
   endtask

   task automatic drain();
      bit f;
      bk_valid = 1'b0;
      for (int i = 0; i < 64 && exp_q.size() != 0; i++) cycle(f);
      cycle(f);
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d beats still pending after 64 cycles", exp_q.size());
      end
   endtask

   initial begin
      bit       f;
      tb_beat_t b;
      vectors = 0; miscompares = 0;
      exp_cnt = '0; exp_inpkt = 1'b0; ready_ok = 1'b0; tready_mode = 0;
      axi_areset = 1'b1; axis_tready = 1'b0;
      bk_valid = 1'b0; bk_data = '0; bk_tstrb = '0; bk_tkeep = '0;
      bk_tlast = 1'b0; bk_tid = '0; bk_user = '0;
      cur = '0;

      // Reset state
      #12;
      chk("rst_tvalid",  axis_tvalid, 1'b0);
      chk("rst_bkready", bk_ready,    1'b0);
      chk("rst_pkt_cnt", pkt_cnt,     '0);
      chk("rst_inpkt",   in_packet,   1'b0);
      @(negedge axi_aclk);
      axi_areset = 1'b0;
      cycle(f);                         // bk_ready still low before first edge

      // Back-to-back stream
      axis_tready = 1'b1;
      send(mk(32'h11, 1'b0));
      send(mk(32'h22, 1'b0));
      send(mk(32'h33, 1'b1));
      drain();
      chk("b2b_pkt_cnt", pkt_cnt, CNT_W'(1));

      // Backpressure: third beat held while the buffer is full
      axis_tready = 1'b0;
      send(mk(32'hA0, 1'b0));
      send(mk(32'hA1, 1'b0));
      drive(mk(32'hA2, 1'b1));
      for (int i = 0; i < 3; i++) cycle(f);
      chk("bp_bkready", bk_ready, 1'b0);
      chk("bp_hold",    axis_tdata, 32'hA0);
      axis_tready = 1'b1;
      wait_fire();
      drain();

      // Single-beat packet with sidebands
      b = '{data: 32'hDEADBEEF, strb: 4'hF, keep: 4'h7, last: 1'b1, id: 2'd2, user: 2'd1};
      send(b);
      drain();
      chk("single_inpkt", in_packet, 1'b0);

      // In-packet flag with toggling tready
      tready_mode = 1;
      send(mk(32'hC0, 1'b0));
      send(mk(32'hC1, 1'b0));
      send(mk(32'hC2, 1'b1));
      tready_mode = 0;
      axis_tready = 1'b1;
      drain();

      // Asynchronous reset while FULL
      axis_tready = 1'b0;
      send(mk(32'hB0, 1'b0));
      send(mk(32'hB1, 1'b1));
      chk("full_tvalid", axis_tvalid, 1'b1);
      #2 axi_areset = 1'b1;
      #1;
      chk("arst_tvalid",  axis_tvalid, 1'b0);
      chk("arst_pkt_cnt", pkt_cnt,     '0);
      chk("arst_inpkt",   in_packet,   1'b0);
      chk("arst_bkready", bk_ready,    1'b0);
      exp_q.delete(); exp_cnt = '0; exp_inpkt = 1'b0; ready_ok = 1'b0;
      @(negedge axi_aclk);
      axi_areset = 1'b0;
      axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) cycle(f);
      send(mk(32'hE0, 1'b1));
      drain();

      // Counter wrap: 17 single-beat packets after the one above
      for (int i = 0; i < 17; i++) send(mk(32'h100 + i, 1'b1));
      drain();
      chk("wrap_pkt_cnt", pkt_cnt, CNT_W'(18 % 16));

      // Random traffic
      tready_mode = 2;
      for (int i = 0; i < 400; i++) begin
         if (!bk_valid && $urandom_range(0, 3) != 0) begin
            b = '{data: $urandom, strb: 4'($urandom_range(0, 15)), keep: 4'($urandom_range(0, 15)),
                  last: ($urandom_range(0, 3) == 0), id: 2'($urandom_range(0, 3)),
                  user: 2'($urandom_range(0, 3))};
            drive(b);
         end
         cycle(f);
         if (f) bk_valid = 1'b0;
      end
      tready_mode = 0;
      axis_tready = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axis_master.md
Name: axis_master

Overview:
- Transmit-side AXI-Stream endpoint. It accepts beats from a backend producer over a valid/ready interface and drives them onto an AXI-Stream master port.
- A 2-entry skid buffer gives full throughput (1 beat/cycle) with registered AXIS outputs. Backpressure is propagated as a registered bk_ready.
- Also provides packet bookkeeping: a count of completed packets and an in-packet flag.

Parameters:
- DATA_WIDTH, 32, width of tdata; tstrb and tkeep are DATA_WIDTH/8.
- TID_WIDTH, 2, width of tid.
- TUSER_WIDTH, 2, width of tuser.
- CNT_WIDTH, 16, width of the packet counter.

Ports:
- axi_aclk  in  1  clock
- axi_areset  in  1  asynchronous reset, active-high
- bk_data  in  DATA_WIDTH  backend beat data
- bk_tstrb  in  DATA_WIDTH/8  backend byte strobes
- bk_tkeep  in  DATA_WIDTH/8  backend byte keeps
- bk_tid  in  TID_WIDTH  backend stream id
- bk_user  in  TUSER_WIDTH  backend user sideband
- bk_tlast  in  1  last beat of packet
- bk_valid  in  1  backend beat valid
- bk_ready  out  1  block can accept a beat
- axis_tvalid  out  1  AXIS valid
- axis_tdata  out  DATA_WIDTH  AXIS data
- axis_tstrb  out  DATA_WIDTH/8  AXIS strobes
- axis_tkeep  out  DATA_WIDTH/8  AXIS keeps
- axis_tlast  out  1  AXIS last
- axis_tid  out  TID_WIDTH  AXIS id
- axis_tuser  out  TUSER_WIDTH  AXIS user
- axis_tready  in  1  downstream ready
- pkt_cnt  out  CNT_WIDTH  packets sent (wraps)
- in_packet  out  1  a packet has started but its tlast beat has not yet been sent

Behaviour:
- Reset (axi_areset=1, asynchronous):
  - State goes to EMPTY; all payload registers clear to 0.
  - axis_tvalid=0, bk_ready=0, pkt_cnt=0, in_packet=0.
  - In-flight beats are discarded.
  - bk_ready rises in the first cycle after reset deasserts.
- Handshakes:
  - in_fire = bk_valid & bk_ready.
  - out_fire = axis_tvalid & axis_tready.
- Storage: main register M drives all axis_* outputs directly; skid register S holds one overflow beat.
- State machine (occupancy); bk_ready = (state != FULL), decoded from the state register only, with no combinational path from axis_tready.
  - EMPTY, axis_tvalid=0: in_fire -> M<=bk beat, go to ONE.
  - ONE, axis_tvalid=1:
    - in_fire & out_fire -> M<=bk beat, stay in ONE.
    - out_fire only -> EMPTY.
    - in_fire only -> S<=bk beat, go to FULL.
    - neither -> hold.
  - FULL, axis_tvalid=1, bk_ready=0: out_fire -> M<=S, go to ONE; otherwise hold.
- Latency: a beat accepted at clock edge N appears on the axis_* outputs after edge N (cycle N+1) when the buffer was EMPTY.
- Throughput: sustained 1 beat/cycle while axis_tready=1.
- AXIS compliance:
  - Once axis_tvalid=1, all axis_* payload outputs stay stable and tvalid stays high until out_fire.
  - tvalid never depends combinationally on tready.
- Ordering: strict FIFO. No beat is dropped or duplicated. Sideband fields travel with their beat unmodified.
- Counters:
  - On out_fire with axis_tlast=1: pkt_cnt<=pkt_cnt+1, wrapping from 2^CNT_WIDTH-1 to 0; in_packet<=0.
  - On out_fire with axis_tlast=0: in_packet<=1.
  - A single-beat packet (tlast on the first beat) increments pkt_cnt and leaves in_packet at 0.
- bk_valid while bk_ready=0 has no effect. The backend holds its beat until in_fire.

Decomposition:
- Shared package axis_pkg:
  - enum axis_mst_state_e {AXIS_MST_EMPTY, AXIS_MST_ONE, AXIS_MST_FULL}.
  - Packed struct axis_beat_t {tdata, tstrb, tkeep, tlast, tid, tuser} using the default widths.
- Sub-module: axis_pkt_counter, holding the pkt_cnt/in_packet logic. Inputs: fire and last; clock and reset as above.

Test Plan:
- Back-to-back stream: axis_tready=1; backend sends 0x11,0x22,0x33 on consecutive cycles with tlast on 0x33 -> axis_tdata shows 0x11,0x22,0x33 on consecutive cycles starting 1 cycle later; pkt_cnt=1; bk_ready stays 1 throughout.
- Backpressure: axis_tready=0; backend sends 0xA0,0xA1,0xA2 -> 0xA0 and 0xA1 are accepted, bk_ready drops to 0 with 0xA2 held, axis_tdata holds 0xA0; then axis_tready=1 -> output order is 0xA0,0xA1,0xA2 with no loss.
- Single-beat packet: 0xDEADBEEF with tlast=1, tid=2, tuser=1, tstrb=0xF -> one AXIS beat carrying identical sidebands; pkt_cnt=1, in_packet stays 0.
- In-packet flag: send a 3-beat packet with axis_tready toggling 1/0 -> in_packet=1 after beat 1 fires, returns to 0 after the tlast beat fires; pkt_cnt increments exactly once.
- Reset mid-operation: state FULL, axis_tvalid=1; assert axi_areset asynchronously -> axis_tvalid=0 immediately, pkt_cnt=0; after deassertion bk_ready=1 and the old beats never appear on axis_tdata.
- Counter wrap (CNT_WIDTH=4): send 17 single-beat packets -> pkt_cnt reads 15 then 0 then 1.
